// File: rtl/pc_unit.sv
// Program-counter unit for the 8051 core: increment, relative/absolute/indirect jumps,
// and CALL/RET/interrupt entry through an internal return-address stack.
module pc_unit #(
    parameter int unsigned     PC_W        = 16,
    parameter int unsigned     STACK_DEPTH = 8,
    parameter int unsigned     NUM_INT     = 5,
    parameter logic [PC_W-1:0] INT_BASE    = PC_W'(16'h0003),
    parameter int unsigned     INT_STRIDE  = 8,
    localparam int unsigned    ID_W        = (NUM_INT > 1) ? $clog2(NUM_INT) : 1,
    localparam int unsigned    SP_W        = $clog2(STACK_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      op,
    input  logic [7:0]      rel8,
    input  logic [PC_W-1:0] addr,
    input  logic [7:0]      acc,
    input  logic [PC_W-1:0] dptr,
    input  logic            int_ack,
    input  logic [ID_W-1:0] int_id,
    output logic [PC_W-1:0] pc,
    output logic [SP_W-1:0] sp,
    output logic            stk_full,
    output logic            stk_empty,
    output logic            stk_err
);

    localparam int unsigned AW = $clog2(STACK_DEPTH);

    localparam logic [2:0] OpHold = 3'd0;
    localparam logic [2:0] OpInc  = 3'd1;
    localparam logic [2:0] OpRel  = 3'd2;
    localparam logic [2:0] OpLjmp = 3'd3;
    localparam logic [2:0] OpAjmp = 3'd4;
    localparam logic [2:0] OpJmpa = 3'd5;
    localparam logic [2:0] OpCall = 3'd6;
    localparam logic [2:0] OpRet  = 3'd7;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    logic            full, empty;
    logic            push, pop;
    logic            push_ok, pop_ok;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] rel_ext, acc_ext, vec;
    logic [SP_W-1:0] sp_dec;
    logic [AW-1:0]   wr_idx, rd_idx;

    assign full   = (sp_q == SP_W'(STACK_DEPTH));
    assign empty  = (sp_q == '0);
    assign sp_dec = sp_q - 1'b1;
    assign wr_idx = sp_q[AW-1:0];
    assign rd_idx = sp_dec[AW-1:0];

    assign rel_ext = {{(PC_W-8){rel8[7]}}, rel8};
    assign acc_ext = {{(PC_W-8){1'b0}}, acc};
    // Out-of-range source ids still follow the vector formula.
    assign vec     = INT_BASE + PC_W'(int_id) * PC_W'(INT_STRIDE);

    // Command decode: int_ack pre-empts whatever op the control unit presents.
    always_comb begin
        target = pc_q;
        push   = 1'b0;
        pop    = 1'b0;
        if (int_ack) begin
            target = vec;
            push   = 1'b1;
        end else begin
            unique case (op)
                OpHold: target = pc_q;
                OpInc:  target = pc_q + 1'b1;
                OpRel:  target = pc_q + rel_ext;
                OpLjmp: target = addr;
                OpAjmp: target = {pc_q[PC_W-1:11], addr[10:0]};
                OpJmpa: target = dptr + acc_ext;
                OpCall: begin
                    target = addr;
                    push   = 1'b1;
                end
                OpRet: begin
                    target = pc_q;
                    pop    = 1'b1;
                end
                default: target = pc_q;
            endcase
        end
    end

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        pc_d  = target;
        sp_d  = sp_q;
        err_d = err_q | (push && full) | (pop && empty);
        if (push_ok) begin
            sp_d = sp_q + 1'b1;
        end
        if (pop) begin
            // Empty-stack RET leaves pc where it was.
            pc_d = pop_ok ? stack_q[rd_idx] : pc_q;
            if (pop_ok) begin
                sp_d = sp_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            stack_q[wr_idx] <= pc_q;
        end
    end

    assign pc        = pc_q;
    assign sp        = sp_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table for single-cycle commands plus
// hand-written stack overflow/underflow and reset sequences.
module tb_pc_unit;

    localparam int unsigned PC_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      op;
    logic [7:0]      rel8;
    logic [PC_W-1:0] addr;
    logic [7:0]      acc;
    logic [PC_W-1:0] dptr;
    logic            int_ack;
    logic [2:0]      int_id;
    logic [PC_W-1:0] pc;
    logic [3:0]      sp;
    logic            stk_full;
    logic            stk_empty;
    logic            stk_err;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .rel8      (rel8),
        .addr      (addr),
        .acc       (acc),
        .dptr      (dptr),
        .int_ack   (int_ack),
        .int_id    (int_id),
        .pc        (pc),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  rel8;
        logic [15:0] addr;
        logic [7:0]  acc;
        logic [15:0] dptr;
        logic        ack;
        logic [2:0]  id;
        logic [15:0] exp_pc;
        logic [3:0]  exp_sp;
        logic        exp_err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [15:0] exp_pc, input logic [3:0] exp_sp,
                         input logic exp_err);
        total += 4;
        if (pc !== exp_pc) begin
            bad++;
            $display("FAIL %s pc got=%h want=%h", name, pc, exp_pc);
        end
        if (sp !== exp_sp) begin
            bad++;
            $display("FAIL %s sp got=%0d want=%0d", name, sp, exp_sp);
        end
        if (stk_err !== exp_err) begin
            bad++;
            $display("FAIL %s stk_err got=%b want=%b", name, stk_err, exp_err);
        end
        if (stk_full !== (exp_sp == 4'd8) || stk_empty !== (exp_sp == 4'd0)) begin
            bad++;
            $display("FAIL %s flags got full=%b empty=%b want sp=%0d", name, stk_full, stk_empty,
                     exp_sp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic ack,
                         input logic [2:0] id, input logic r);
        @(negedge clk);
        op      = o;
        addr    = a;
        int_ack = ack;
        int_id  = id;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         op    rel8   addr      acc    dptr      ack   id    pc        sp    err
        vecs[0]  = '{3'd1, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0001, 4'd0, 1'b0};
        vecs[1]  = '{3'd1, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0002, 4'd0, 1'b0};
        vecs[2]  = '{3'd1, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0003, 4'd0, 1'b0};
        vecs[3]  = '{3'd3, 8'h00, 16'h0010, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0010, 4'd0, 1'b0};
        vecs[4]  = '{3'd2, 8'hFE, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h000E, 4'd0, 1'b0};
        vecs[5]  = '{3'd3, 8'h00, 16'hFFF0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'hFFF0, 4'd0, 1'b0};
        vecs[6]  = '{3'd2, 8'h7F, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h006F, 4'd0, 1'b0};
        vecs[7]  = '{3'd3, 8'h00, 16'h1234, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h1234, 4'd0, 1'b0};
        vecs[8]  = '{3'd4, 8'h00, 16'h07FF, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h17FF, 4'd0, 1'b0};
        vecs[9]  = '{3'd5, 8'h00, 16'h0000, 8'hFF, 16'h2000, 1'b0, 3'd0, 16'h20FF, 4'd0, 1'b0};
        vecs[10] = '{3'd0, 8'h00, 16'h5555, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h20FF, 4'd0, 1'b0};
        vecs[11] = '{3'd3, 8'h00, 16'h0100, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0100, 4'd0, 1'b0};
        vecs[12] = '{3'd6, 8'h00, 16'h0400, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0400, 4'd1, 1'b0};
        vecs[13] = '{3'd7, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0100, 4'd0, 1'b0};
        vecs[14] = '{3'd3, 8'h00, 16'h0050, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0050, 4'd0, 1'b0};
        vecs[15] = '{3'd3, 8'h00, 16'h9999, 8'h00, 16'h0000, 1'b1, 3'd2, 16'h0013, 4'd1, 1'b0};
        vecs[16] = '{3'd7, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0050, 4'd0, 1'b0};
        vecs[17] = '{3'd0, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b1, 3'd7, 16'h003B, 4'd1, 1'b0};
        vecs[18] = '{3'd7, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0050, 4'd0, 1'b0};

        rst = 1'b1; op = 3'd0; rel8 = 8'h00; addr = '0; acc = 8'h00; dptr = '0;
        int_ack = 1'b0; int_id = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 16'h0000, 4'd0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst     = 1'b0;
            op      = vecs[i].op;
            rel8    = vecs[i].rel8;
            addr    = vecs[i].addr;
            acc     = vecs[i].acc;
            dptr    = vecs[i].dptr;
            int_ack = vecs[i].ack;
            int_id  = vecs[i].id;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_sp, vecs[i].exp_err);
        end

        // Fill the stack: first entry holds 0x0050, entry k holds 0x0100+k-1.
        for (int i = 0; i < 8; i++) begin
            drive(3'd6, 16'h0100 + 16'(i), 1'b0, 3'd0, 1'b0);
            check($sformatf("fill%0d", i), 16'h0100 + 16'(i), 4'(i + 1), 1'b0);
        end
        drive(3'd6, 16'h0AAA, 1'b0, 3'd0, 1'b0);
        check("call_full", 16'h0AAA, 4'd8, 1'b1);
        drive(3'd0, 16'h0000, 1'b1, 3'd1, 1'b0);
        check("int_full", 16'h000B, 4'd8, 1'b1);
        drive(3'd7, 16'h0000, 1'b0, 3'd0, 1'b0);
        check("ret_after_full", 16'h0106, 4'd7, 1'b1);
        drive(3'd7, 16'h0000, 1'b0, 3'd0, 1'b0);
        check("ret_deeper", 16'h0105, 4'd6, 1'b1);

        // Reset wins over a concurrent jump and discards the stack.
        drive(3'd3, 16'h4321, 1'b1, 3'd0, 1'b1);
        check("rst_prio", 16'h0000, 4'd0, 1'b0);
        drive(3'd7, 16'h0000, 1'b0, 3'd0, 1'b0);
        check("ret_empty", 16'h0000, 4'd0, 1'b1);
        drive(3'd1, 16'h0000, 1'b0, 3'd0, 1'b0);
        check("err_sticky", 16'h0001, 4'd0, 1'b1);

        // Reset between CALL and RET: sp returns to 0 and the RET underflows.
        drive(3'd6, 16'h0300, 1'b0, 3'd0, 1'b1);
        drive(3'd6, 16'h0300, 1'b0, 3'd0, 1'b0);
        check("call_fresh", 16'h0300, 4'd1, 1'b0);
        drive(3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        check("rst_mid", 16'h0000, 4'd0, 1'b0);
        drive(3'd7, 16'h0000, 1'b0, 3'd0, 1'b0);
        check("ret_after_rst", 16'h0000, 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
